// File: rtl/tx_arb_pkg.sv
// Shared definitions for the uart_tx arbiter: FSM state encoding, ASCII
// control characters used by the optional CR/LF expansion, port indices
// and the one-hot grant encodings reported on o_grant.
package tx_arb_pkg;

  // Arbiter FSM states; one byte moves through SEND -> WAIT_DONE -> GAP.
  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_SEND      = 2'd1,
    ST_WAIT_DONE = 2'd2,
    ST_GAP       = 2'd3
  } state_t;

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

  // Port index as carried on the round-robin select line.
  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

  // One-hot owner encodings for o_grant.
  localparam logic [1:0] GRANT_NONE = 2'b00;
  localparam logic [1:0] GRANT_A    = 2'b01;
  localparam logic [1:0] GRANT_B    = 2'b10;

  // Map a port index onto its one-hot grant code.
  function automatic logic [1:0] grant_of(input logic port);
    return (port == PORT_B) ? GRANT_B : GRANT_A;
  endfunction

endpackage

// File: rtl/tx_arb_rr.sv
// Two-way round-robin pointer with packet lock for the uart_tx arbiter.
// While a packet is open (last byte not yet accepted) the owner stays
// selected even when it momentarily has nothing valid, so messages are
// never interleaved. With no lock, a lone requester wins and a tie goes
// to the port that was not served last. Reset leaves B as "served last"
// so A wins the first tie.
module tx_arb_rr
  import tx_arb_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic valid_a,
  input  logic valid_b,
  input  logic accept,   // a byte was handed over this cycle
  input  logic last,     // the accepted byte closes its packet
  input  logic abort,    // watchdog abort: drop any open packet
  output logic select    // PORT_A or PORT_B
);

  logic last_served;
  logic locked;

  // Choose the eligible port from lock state, requests and fairness pointer.
  always_comb begin
    // NOTE: assign every always_comb output up front so no path can
    // leave it unassigned and infer a latch.
    select = ~last_served;
    if (locked) begin
      select = last_served;
    end else if (valid_a && !valid_b) begin
      select = PORT_A;
    end else if (valid_b && !valid_a) begin
      select = PORT_B;
    end
  end

  // Track who was served last and whether their packet is still open.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_served <= PORT_B;
      locked      <= 1'b0;
    end else if (abort) begin
      locked <= 1'b0;
    end else if (accept) begin
      // NOTE: non-blocking assignments in clocked blocks, so every register
      // samples pre-edge values regardless of statement order.
      last_served <= select;
      locked      <= ~last;
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one uart_tx between port A (terminal echo) and port B (status and
// banner messages). Round-robin arbitration with packet lock picks a source
// in IDLE, the accepted byte is strobed into uart_tx for one cycle, the FSM
// waits for the done pulse (bounded by a watchdog) and inserts a one-cycle
// gap before the next arbitration.
//
// Build option: define TX_ARB_CRLF_EN to send every accepted 0x0A as the
// pair 0x0D, 0x0A (the LF follows the CR's gap without a new handshake).
// Without it, bytes pass through unchanged with one strobe per transfer.
//
// DONE_TIMEOUT: clocks allowed in WAIT_DONE before the transfer is aborted;
// 0 disables the watchdog.
module uart_tx_arbiter
  import tx_arb_pkg::*;
#(
  parameter int DONE_TIMEOUT = 16384
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] i_a_byte,
  input  logic       i_a_valid,
  input  logic       i_a_last,
  output logic       o_a_ready,
  input  logic [7:0] i_b_byte,
  input  logic       i_b_valid,
  input  logic       i_b_last,
  output logic       o_b_ready,
  output logic [7:0] o_tx_byte,
  output logic       o_tx_dv,
  input  logic       i_tx_active,
  input  logic       i_tx_done,
  output logic [1:0] o_grant,
  output logic       o_busy,
  output logic       o_timeout
);

`ifdef TX_ARB_CRLF_EN
  localparam bit CRLF_EN = 1'b1;
`else
  localparam bit CRLF_EN = 1'b0;
`endif

  // The counter runs 0 .. DONE_TIMEOUT-1 inside WAIT_DONE.
  localparam int CNT_W = (DONE_TIMEOUT > 1) ? $clog2(DONE_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'((DONE_TIMEOUT > 0) ? DONE_TIMEOUT - 1 : 0);

  state_t           state;
  logic [CNT_W-1:0] count;
  logic             crlf_pending;  // CR is in flight, LF still owed
  logic             select;
  logic             idle;
  logic             accept;
  logic [7:0]       acc_byte;
  logic             acc_last;
  logic             expired;
  logic             abort;

  assign idle = (state == ST_IDLE);

  // Ready is combinational so a byte can be accepted in the first IDLE
  // cycle; it is held low while reset is asserted.
  assign o_a_ready = rst_n && idle && (select == PORT_A) && i_a_valid;
  assign o_b_ready = rst_n && idle && (select == PORT_B) && i_b_valid;
  assign accept    = o_a_ready || o_b_ready;

  assign acc_byte = (select == PORT_B) ? i_b_byte : i_a_byte;
  assign acc_last = (select == PORT_B) ? i_b_last : i_a_last;

  // A done pulse in the expiry cycle wins over the watchdog.
  assign expired = (DONE_TIMEOUT != 0) && (count == CNT_LAST);
  assign abort   = (state == ST_WAIT_DONE) && !i_tx_done && expired;

  tx_arb_rr u_rr (
    .clk     (clk),
    .rst_n   (rst_n),
    .valid_a (i_a_valid),
    .valid_b (i_b_valid),
    .accept  (accept),
    .last    (acc_last),
    .abort   (abort),
    .select  (select)
  );

  // Transfer sequencer: state, watchdog counter and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: outputs sit in the async reset branch so they clear the moment
      // rst_n falls, abandoning any byte in flight without waiting for a clock.
      state        <= ST_IDLE;
      count        <= '0;
      crlf_pending <= 1'b0;
      o_tx_byte    <= 8'h00;
      o_tx_dv      <= 1'b0;
      o_grant      <= GRANT_NONE;
      o_busy       <= 1'b0;
      o_timeout    <= 1'b0;
    end else begin
      o_tx_dv   <= 1'b0;
      o_timeout <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            state   <= ST_SEND;
            o_tx_dv <= 1'b1;
            o_busy  <= 1'b1;
            o_grant <= grant_of(select);
            if (CRLF_EN && (acc_byte == ASCII_LF)) begin
              o_tx_byte    <= ASCII_CR;
              crlf_pending <= 1'b1;
            end else begin
              o_tx_byte <= acc_byte;
            end
          end
        end
        ST_SEND: begin
          state <= ST_WAIT_DONE;
          count <= '0;
        end
        ST_WAIT_DONE: begin
          if (i_tx_done) begin
            state <= ST_GAP;
          end else if (expired) begin
            // Abort: the owner's lock is released inside tx_arb_rr and any
            // LF still owed after a CR is dropped along with it.
            state        <= ST_GAP;
            o_timeout    <= 1'b1;
            crlf_pending <= 1'b0;
          end else if (DONE_TIMEOUT != 0) begin
            count <= count + 1'b1;
          end
        end
        ST_GAP: begin
          if (crlf_pending) begin
            state        <= ST_SEND;
            o_tx_dv      <= 1'b1;
            o_tx_byte    <= ASCII_LF;
            crlf_pending <= 1'b0;
          end else begin
            state  <= ST_IDLE;
            o_busy <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // uart_tx must report itself busy for as long as we wait on its done pulse.
  a_tx_active_in_wait : assert property (@(posedge clk) disable iff (!rst_n)
    ((state == ST_WAIT_DONE) && !i_tx_done) |-> i_tx_active);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed and randomized bench for uart_tx_arbiter. A small uart_tx stand-in
// answers each strobe with a done pulse after a frame time (or stays silent
// to provoke the watchdog). Transmitted byte order is checked against a
// transaction-level model of round-robin-with-packet-lock arbitration.
`timescale 1ns/1ps
module tb_uart_tx_arbiter;

  localparam int TO = 100;
`ifdef TX_ARB_CRLF_EN
  localparam bit CRLF = 1'b1;
`else
  localparam bit CRLF = 1'b0;
`endif

  typedef struct packed {
    logic [7:0] data;
    logic       last;
  } beat_t;
  typedef beat_t beat_q_t[$];

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] a_byte, b_byte;
  logic       a_valid, a_last, b_valid, b_last;
  logic       a_ready, b_ready;
  logic [7:0] o_tx_byte;
  logic       o_tx_dv;
  logic       tx_active, tx_done;
  logic [1:0] o_grant;
  logic       o_busy, o_timeout;

  beat_q_t    qa, qb;
  logic [7:0] tx_log[$];
  logic [7:0] exp_q[$];
  int         vectors = 0;
  int         miscompares = 0;
  bit         mute = 1'b0;
  int         fixed_frame = 4;

  uart_tx_arbiter #(.DONE_TIMEOUT(TO)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_a_byte    (a_byte),
    .i_a_valid   (a_valid),
    .i_a_last    (a_last),
    .o_a_ready   (a_ready),
    .i_b_byte    (b_byte),
    .i_b_valid   (b_valid),
    .i_b_last    (b_last),
    .o_b_ready   (b_ready),
    .o_tx_byte   (o_tx_byte),
    .o_tx_dv     (o_tx_dv),
    .i_tx_active (tx_active),
    .i_tx_done   (tx_done),
    .o_grant     (o_grant),
    .o_busy      (o_busy),
    .o_timeout   (o_timeout)
  );

  always #5 clk = ~clk;

  // uart_tx stand-in: log each strobed byte, stay active for the frame,
  // then pulse done. When muted it never answers.
  initial begin
    int f;
    tx_active = 1'b0;
    tx_done   = 1'b0;
    forever begin
      @(negedge clk);
      if (o_tx_dv === 1'b1) begin
        tx_log.push_back(o_tx_byte);
        tx_active = 1'b1;
        if (mute) begin
          while (mute) @(negedge clk);
          tx_active = 1'b0;
        end else begin
          f = (fixed_frame > 0) ? fixed_frame : int'($urandom_range(1, 6));
          repeat (f) @(negedge clk);
          tx_done = 1'b1;
          @(negedge clk);
          tx_done   = 1'b0;
          tx_active = 1'b0;
        end
      end
    end
  end

  // Hard stop in case the sequence itself wedges.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Expected transmit order: an open packet keeps its owner, otherwise a
  // lone requester wins and a tie goes to whoever was not served last.
  function automatic void predict(input beat_q_t a_in, input beat_q_t b_in);
    beat_q_t a = a_in;
    beat_q_t b = b_in;
    int      owner = 1;  // B counts as served last out of reset
    bit      locked = 1'b0;
    int      pick;
    beat_t   bt;
    exp_q.delete();
    while (a.size() != 0 || b.size() != 0) begin
      if (locked && ((owner == 0) ? a.size() : b.size()) != 0) pick = owner;
      else if (a.size() != 0 && b.size() != 0) pick = 1 - owner;
      else pick = (a.size() != 0) ? 0 : 1;
      if (pick == 1) bt = b.pop_front();
      else bt = a.pop_front();
      owner  = pick;
      locked = !bt.last;
      if (CRLF && bt.data == 8'h0A) exp_q.push_back(8'h0D);
      exp_q.push_back(bt.data);
    end
  endfunction

  task automatic compare_log(input string tag);
    check({tag, "_len"}, tx_log.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < tx_log.size(); i++)
      check(tag, {24'h0, tx_log[i]}, {24'h0, exp_q[i]});
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    do begin
      @(negedge clk);
      #1;
      n++;
    end while (o_busy && n < 500);
    check(tag, n < 500, 1);
  endtask

  // Present queued beats on both ports (AXI-style hold) until everything
  // is accepted and sent; count handshakes, strobes and timeouts.
  task automatic run_stream(input int budget, output int accepts, output int dvs,
                            output int touts, output int b_early);
    int cyc = 0;
    bit hs = 1'b0;
    accepts = 0;
    dvs     = 0;
    touts   = 0;
    b_early = 0;
    tx_log.delete();
    while ((qa.size() != 0 || qb.size() != 0 || o_busy || hs) && cyc < budget) begin
      @(negedge clk);
      a_valid = (qa.size() != 0);
      b_valid = (qb.size() != 0);
      if (a_valid) begin a_byte = qa[0].data; a_last = qa[0].last; end
      if (b_valid) begin b_byte = qb[0].data; b_last = qb[0].last; end
      #1;
      hs = 1'b0;
      if (o_tx_dv) dvs++;
      if (o_timeout) touts++;
      if (b_ready && qa.size() != 0) b_early++;
      if (a_valid && a_ready) begin void'(qa.pop_front()); accepts++; hs = 1'b1; end
      if (b_valid && b_ready) begin void'(qb.pop_front()); accepts++; hs = 1'b1; end
      cyc++;
    end
    a_valid = 1'b0;
    b_valid = 1'b0;
    check("stream_budget", cyc < budget, 1);
  endtask

  initial begin
    int    acc, dvs, touts, b_early, k, len;
    beat_t bt;
    rst_n = 1'b0;
    a_byte = 8'h00; a_valid = 1'b0; a_last = 1'b0;
    b_byte = 8'h00; b_valid = 1'b0; b_last = 1'b0;

    // Reset state
    #2;
    check("rst_dv", o_tx_dv, 0);
    check("rst_byte", o_tx_byte, 0);
    check("rst_a_ready", a_ready, 0);
    check("rst_b_ready", b_ready, 0);
    check("rst_grant", o_grant, 0);
    check("rst_busy", o_busy, 0);
    check("rst_timeout", o_timeout, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Single byte from A: timing of ready, strobe, gap and idle
    fixed_frame = 4;
    @(negedge clk);
    a_byte = 8'h41; a_last = 1'b1; a_valid = 1'b1;
    #1;
    check("t1_a_ready", a_ready, 1);
    check("t1_b_ready", b_ready, 0);
    @(negedge clk);
    a_valid = 1'b0;
    #1;
    check("t1_dv", o_tx_dv, 1);
    check("t1_byte", o_tx_byte, 8'h41);
    check("t1_grant", o_grant, 2'b01);
    check("t1_busy", o_busy, 1);
    repeat (5) @(negedge clk);
    #1;
    check("t1_gap_busy", o_busy, 1);
    check("t1_gap_dv", o_tx_dv, 0);
    @(negedge clk);
    #1;
    check("t1_idle_busy", o_busy, 0);
    check("t1_byte_hold", o_tx_byte, 8'h41);

    // Both ports contending with single-byte packets: strict alternation
    apply_reset();
    fixed_frame = 0;
    qa.push_back('{data: 8'h41, last: 1'b1});
    qa.push_back('{data: 8'h41, last: 1'b1});
    qb.push_back('{data: 8'h42, last: 1'b1});
    qb.push_back('{data: 8'h42, last: 1'b1});
    exp_q = '{8'h41, 8'h42, 8'h41, 8'h42};
    run_stream(500, acc, dvs, touts, b_early);
    compare_log("t2_order");
    check("t2_grant_b", o_grant, 2'b10);

    // "HI" from A is not interleaved with B's waiting byte
    qa.push_back('{data: 8'h48, last: 1'b0});
    qa.push_back('{data: 8'h49, last: 1'b1});
    qb.push_back('{data: 8'h58, last: 1'b1});
    exp_q = '{8'h48, 8'h49, 8'h58};
    run_stream(500, acc, dvs, touts, b_early);
    compare_log("t3_order");
    check("t3_b_ready_early", b_early, 0);

    // Done arriving in the very cycle the watchdog expires: done wins
    fixed_frame = TO;
    qa.push_back('{data: 8'h5A, last: 1'b1});
    exp_q = '{8'h5A};
    run_stream(500, acc, dvs, touts, b_early);
    compare_log("t4_order");
    check("t4_no_timeout", touts, 0);

    // Watchdog abort: pulse position, width, return to IDLE and lock release
    mute = 1'b1;
    @(negedge clk);
    a_byte = 8'h55; a_last = 1'b0; a_valid = 1'b1;
    #1;
    check("t5_a_ready", a_ready, 1);
    @(negedge clk);
    a_valid = 1'b0;
    #1;
    check("t5_dv", o_tx_dv, 1);
    k = 0;
    while (!o_timeout && k < 300) begin
      @(negedge clk);
      #1;
      k++;
    end
    check("t5_timeout_cycle", k, TO + 1);
    check("t5_gap_busy", o_busy, 1);
    @(negedge clk);
    #1;
    check("t5_pulse_width", o_timeout, 0);
    check("t5_idle", o_busy, 0);
    mute = 1'b0;
    fixed_frame = 3;
    repeat (2) @(negedge clk);
    b_byte = 8'h66; b_last = 1'b1; b_valid = 1'b1;
    #1;
    check("t5_unlocked_b_ready", b_ready, 1);
    @(negedge clk);
    b_valid = 1'b0;
    wait_idle("t5_b_idle");
    check("t5_b_sent", {24'h0, tx_log[$]}, 32'h66);

    // Reset during WAIT_DONE, then A must win the first tie
    mute = 1'b1;
    @(negedge clk);
    a_byte = 8'h77; a_last = 1'b1; a_valid = 1'b1;
    @(negedge clk);
    a_valid = 1'b0;
    repeat (3) @(negedge clk);
    #3;
    check("t6_busy_before", o_busy, 1);
    rst_n = 1'b0;
    #1;
    check("t6_rst_dv", o_tx_dv, 0);
    check("t6_rst_busy", o_busy, 0);
    check("t6_rst_grant", o_grant, 0);
    check("t6_rst_byte", o_tx_byte, 0);
    mute = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    qa.push_back('{data: 8'h31, last: 1'b1});
    qb.push_back('{data: 8'h32, last: 1'b1});
    exp_q = '{8'h31, 8'h32};
    run_stream(500, acc, dvs, touts, b_early);
    compare_log("t6_order");

    // Line feed: one handshake, CR+LF only when the expansion is built in
    fixed_frame = 0;
    qa.push_back('{data: 8'h0A, last: 1'b1});
    predict(qa, qb);
    run_stream(500, acc, dvs, touts, b_early);
    check("t7_accepts", acc, 1);
    check("t7_dv_count", dvs, CRLF ? 2 : 1);
    compare_log("t7_bytes");

    // Randomized packets on both ports against the arbitration model
    apply_reset();
    for (int p = 0; p < 2; p++) begin
      for (int n = 0; n < 6; n++) begin
        len = int'($urandom_range(1, 3));
        for (int j = 0; j < len; j++) begin
          bt.data = ($urandom_range(0, 7) == 0) ? 8'h0A : 8'($urandom);
          bt.last = (j == len - 1);
          if (p == 0) qa.push_back(bt);
          else qb.push_back(bt);
        end
      end
    end
    predict(qa, qb);
    run_stream(4000, acc, dvs, touts, b_early);
    check("t8_no_timeout", touts, 0);
    check("t8_dv_count", dvs, exp_q.size());
    compare_log("t8_order");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
